// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter
//
// Shares one parity-check datapath between NUM_REQ requesters. The block sits
// between serial receivers (UART/SPI front ends) and the status/interrupt
// logic.
//
// Operation:
//   - A round-robin arbiter picks one pending request while the FSM is IDLE.
//   - The winning word is captured and checked in CHECK.
//   - The result is offered on a valid/ready response port in RESP, tagged
//     with the requester id.
//
// Timing: with rsp_ready held high the FSM visits IDLE, CHECK and RESP once
// per transaction, so one word is checked every three cycles. rsp_valid
// rises on the second clock edge, counting the accept edge as the first.
//
// Optional feature (macro PARITY_ERR_CNT_EN):
//   - When defined, keeps a saturating per-requester error counter that
//     cnt_clr can zero.
//   - When undefined, err_cnt is tied to zero and no counter flops exist.

package parity_types_pkg;

    // Parity convention a requester asks for: EVEN wants an even number of
    // ones over data plus parity bit, ODD wants an odd number.
    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } parity_t;

endpackage

module parity_check_arbiter
    import parity_types_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_par,
    input  logic [NUM_REQ-1:0]           req_type,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err,

    input  logic                         cnt_clr,
    output logic [NUM_REQ*CNT_W-1:0]     err_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);

    // One state per phase of a transaction.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // Round-robin pointer: the requester with the highest priority next.
    logic [ID_W-1:0]    rr_ptr;

    // Arbitration result for the current cycle.
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W:0]      cand;
    logic               accept;

    // Captured request, held while the check is in progress.
    logic [DATA_W-1:0]  cap_data;
    logic               cap_par;
    parity_t            cap_type;
    logic [ID_W-1:0]    cap_id;

    // Handshake on the response port.
    logic               rsp_fire;

    assign accept   = (state_q == IDLE) && grant_found;
    assign rsp_fire = rsp_valid && rsp_ready;

    // Round-robin search from rr_ptr upward, wrapping modulo NUM_REQ.
    //   - The loop runs from the farthest candidate down to rr_ptr itself,
    //     so the last match written is the closest one.
    //   - The wrap uses a single subtract, because rr_ptr + k never reaches
    //     2*NUM_REQ. This works for sizes that are not a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
            if (req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    // The grant is shown only while IDLE, so a requester sees at most one
    // accept per transaction.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    //   - CHECK always lasts exactly one cycle.
    //   - RESP waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the winning request and advance the round-robin pointer.
    // A request that drops before the edge captures nothing and leaves the
    // pointer alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            cap_data <= '0;
            cap_par  <= 1'b0;
            cap_type <= EVEN;
            cap_id   <= '0;
        end else if (accept) begin
            cap_data <= req_data[grant_id*DATA_W +: DATA_W];
            cap_par  <= req_par[grant_id];
            cap_type <= parity_t'(req_type[grant_id]);
            cap_id   <= grant_id;
            if (grant_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + ID_W'(1);
            end
        end
    end

    // Compute the result in CHECK and hold it through RESP until the
    // consumer takes it.
    //   - The error is the XOR of all data bits, the received parity bit
    //     and the parity type.
    //   - The rsp_* fields keep their last value after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state_q == CHECK) begin
                rsp_valid <= 1'b1;
                rsp_id    <= cap_id;
                rsp_data  <= cap_data;
                rsp_err   <= (^cap_data) ^ cap_par ^ (cap_type == ODD);
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN

    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // Per-requester error counters.
    //   - A counter bumps on each handshaken error response for its
    //     requester and stops at all-ones.
    //   - cnt_clr wins over an increment on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (rsp_fire && rsp_err) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((rsp_id == ID_W'(i)) && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten the counters onto the output bus, requester i at lane i.
    always_comb begin
        err_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            err_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

`else

    // Without the counter feature the bus is constant and cnt_clr has no
    // effect.
    logic unused_cnt_inputs;

    assign err_cnt           = '0;
    assign unused_cnt_inputs = cnt_clr ^ rsp_fire;

`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Testbench for parity_check_arbiter.
//
// Two instances share one clock and one reset:
//   - dut: the main instance, with NUM_REQ=4 and CNT_W=2.
//   - dut3: a second instance with NUM_REQ=3, used to check the
//     round-robin wrap at a size that is not a power of two.
//
// Expected values come from a transaction-level model:
//   - The round-robin pointer is kept as an integer.
//   - The winner is found with modulo arithmetic.
//   - Parity is derived from a population count.
//   - Each error counter is a saturating integer.

module tb_parity_check_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 2;
    localparam int N3  = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_par;
    logic [N-1:0]    req_type;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            cnt_clr;
    logic [N*CW-1:0] err_cnt;

    logic [N3-1:0]    b_req_valid;
    logic [N3-1:0]    b_req_ready;
    logic [N3*DW-1:0] b_req_data;
    logic [N3-1:0]    b_req_par;
    logic [N3-1:0]    b_req_type;
    logic             b_rsp_valid;
    logic             b_rsp_ready;
    logic [1:0]       b_rsp_id;
    logic [DW-1:0]    b_rsp_data;
    logic             b_rsp_err;
    logic [N3*8-1:0]  b_err_cnt;

    int checks;
    int fails;
    int mdl_ptr;
    int mdl_cnt [N];

    parity_check_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_par   (req_par),
        .req_type  (req_type),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .cnt_clr   (cnt_clr),
        .err_cnt   (err_cnt)
    );

    parity_check_arbiter #(.NUM_REQ(N3), .DATA_W(DW), .CNT_W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_data  (b_req_data),
        .req_par   (b_req_par),
        .req_type  (b_req_type),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_id    (b_rsp_id),
        .rsp_data  (b_rsp_data),
        .rsp_err   (b_rsp_err),
        .cnt_clr   (1'b0),
        .err_cnt   (b_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Model: first valid requester at or after the pointer, modulo N.
    function automatic int expectedWinner(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mdl_ptr + k) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // Model: the error flag is set when the parity of the ones count does
    // not match the requested type.
    function automatic logic expectedErr(input logic [DW-1:0] d, input logic p,
                                         input logic t);
        int ones;
        ones = $countones(d) + int'(p);
        return ((ones % 2) != int'(t));
    endfunction

    // Compare every error counter lane against the model.
    task automatic checkCounters(input string tag);
        for (int i = 0; i < N; i++) begin
            checkOutput(tag, 32'(err_cnt[i*CW +: CW]), 32'(mdl_cnt[i]));
        end
    endtask

    // Hold reset for three cycles, check the reset outputs, then release it.
    task automatic resetDut();
        rst_n       = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_par     = '0;
        req_type    = '0;
        rsp_ready   = 1'b0;
        cnt_clr     = 1'b0;
        b_req_valid = '0;
        b_req_data  = '0;
        b_req_par   = '0;
        b_req_type  = '0;
        b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 0);
        checkOutput("rst_b_rsp_valid", 32'(b_rsp_valid), 0);
        rst_n   = 1'b1;
        mdl_ptr = 0;
        for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
    endtask

    // One full transaction, entered and left just after a negedge while
    // the DUT is IDLE.
    //   - stall: cycles rsp_ready stays low in RESP.
    //   - clr: assert cnt_clr on the handshake edge.
    //   - hold: keep all requests asserted after the accept.
    task automatic applyStimulus(input logic [N-1:0] mask, input logic [N*DW-1:0] data,
                                 input logic [N-1:0] par, input logic [N-1:0] typ,
                                 input int stall, input bit clr, input bit hold);
        int w;
        logic [DW-1:0] wd;
        logic werr;
        req_valid = mask;
        req_data  = data;
        req_par   = par;
        req_type  = typ;
        rsp_ready = (stall == 0);
        cnt_clr   = 1'b0;
        w = expectedWinner(mask);
        #1;
        checkOutput("req_ready_grant", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w < 0) begin
            @(negedge clk);
            checkOutput("idle_no_rsp", 32'(rsp_valid), 0);
            return;
        end
        wd   = data[w*DW +: DW];
        werr = expectedErr(wd, par[w], typ[w]);
        mdl_ptr = (w + 1) % N;
        @(negedge clk);
        checkOutput("check_req_ready", 32'(req_ready), 0);
        checkOutput("check_rsp_valid", 32'(rsp_valid), 0);
        if (!hold) req_valid = '0;
        @(negedge clk);
        checkOutput("rsp_valid", 32'(rsp_valid), 1);
        checkOutput("rsp_id", 32'(rsp_id), 32'(w));
        checkOutput("rsp_data", 32'(rsp_data), 32'(wd));
        checkOutput("rsp_err", 32'(rsp_err), 32'(werr));
        checkOutput("resp_req_ready", 32'(req_ready), 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_rsp_valid", 32'(rsp_valid), 1);
            checkOutput("stall_rsp_id", 32'(rsp_id), 32'(w));
            checkOutput("stall_rsp_data", 32'(rsp_data), 32'(wd));
            checkOutput("stall_rsp_err", 32'(rsp_err), 32'(werr));
            checkOutput("stall_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        cnt_clr   = clr;
        @(negedge clk);
        if (clr) begin
            for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
        end else if (CNT_EN && werr && mdl_cnt[w] < CNT_MAX) begin
            mdl_cnt[w]++;
        end
        cnt_clr = 1'b0;
        checkOutput("done_rsp_valid", 32'(rsp_valid), 0);
        checkCounters("err_cnt");
    endtask

    // A request that vanishes before the clock edge must leave no trace.
    task automatic applyDroppedRequest(input logic [N-1:0] mask);
        int w;
        req_valid = mask;
        w = expectedWinner(mask);
        #1;
        checkOutput("drop_ready_seen", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        #2;
        req_valid = '0;
        #1;
        checkOutput("drop_ready_gone", 32'(req_ready), 0);
        @(negedge clk);
        checkOutput("drop_no_rsp", 32'(rsp_valid), 0);
        checkOutput("drop_idle_ready", 32'(req_ready), 0);
    endtask

    // Main test sequence: directed cases first, then random traffic and
    // the NUM_REQ=3 wrap check.
    initial begin
        logic [N*DW-1:0] fixed_data;
        checks  = 0;
        fails   = 0;
        mdl_ptr = 0;
        for (int i = 0; i < N; i++) mdl_cnt[i] = 0;

        resetDut();

        // Directed parity cases.
        applyStimulus(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 4'b0000, 4'b0000, 0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 32'h0000_0001, 4'b0000, 4'b0001, 0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 32'h0000_0001, 4'b0001, 4'b0001, 0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 32'h0000_0000, 4'b0001, 4'b0000, 0, 1'b0, 1'b0);

        // All requesters valid continuously, back to back.
        resetDut();
        fixed_data = 32'h3C_81_7E_55;
        for (int t = 0; t < 5; t++) begin
            applyStimulus(4'b1111, fixed_data, 4'b1010, 4'b0110, 0, 1'b0, 1'b1);
        end

        // A single continuous requester wins every time.
        for (int t = 0; t < 3; t++) begin
            applyStimulus(4'b0010, fixed_data, 4'b0010, 4'b0000, 0, 1'b0, 1'b1);
        end

        // Consumer stalls for five cycles, then the next grant follows at once.
        applyStimulus(4'b1111, fixed_data, 4'b0000, 4'b0000, 5, 1'b0, 1'b1);
        applyStimulus(4'b1111, fixed_data, 4'b0000, 4'b0000, 0, 1'b0, 1'b0);

        // A request dropped before the edge leaves the pointer unchanged.
        applyDroppedRequest(4'b1000);
        applyDroppedRequest(4'b0001);
        applyStimulus(4'b1001, 32'hFF00_00FF, 4'b0000, 4'b0000, 0, 1'b0, 1'b0);

        // Reset during CHECK drops the transaction and clears the pointer.
        req_valid = 4'b0100;
        req_data  = 32'h0012_3456;
        #1;
        checkOutput("pre_rst_grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        mdl_ptr = 0;
        for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
        @(negedge clk);
        checkOutput("postrst_no_rsp", 32'(rsp_valid), 0);
        applyStimulus(4'b1111, fixed_data, 4'b0000, 4'b0000, 0, 1'b0, 1'b0);
        applyStimulus(4'b0010, 32'h0000_7700, 4'b0000, 4'b0000, 0, 1'b0, 1'b0);

        // Five erroneous responses on requester 3, then a clear on a
        // handshake edge that also carries an error.
        for (int t = 0; t < 5; t++) begin
            applyStimulus(4'b1000, 32'h0000_0000, 4'b1000, 4'b0000, 0, 1'b0, 1'b0);
        end
        applyStimulus(4'b1000, 32'h0000_0000, 4'b1000, 4'b0000, 0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int t = 0; t < 40; t++) begin
            applyStimulus(4'($urandom_range(0, 15)), 32'($urandom()), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), $urandom_range(0, 2),
                          ($urandom_range(0, 9) == 0), 1'b0);
        end

        // Three-requester instance: the grant order must wrap 0,1,2,0,1.
        b_req_valid = 3'b111;
        b_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (!b_rsp_valid && waited < 12) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("b_rsp_seen", 32'(b_rsp_valid), 1);
            checkOutput("b_rsp_id", 32'(b_rsp_id), 32'(k % N3));
            checkOutput("b_rsp_data", 32'(b_rsp_data), 0);
            checkOutput("b_rsp_err", 32'(b_rsp_err), 0);
            checkOutput("b_req_ready_resp", 32'(b_req_ready), 0);
        end
        b_req_valid = '0;
        @(negedge clk);
        checkOutput("b_err_cnt", 32'(b_err_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
